// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
// Pipeline sequencing for the 5-stage RV32 core. It decides when the IF, ID
// and EX stages advance, hold or take a bubble. Three events are handled:
//   - load-use stalls found in ID
//   - taken-branch flushes resolved in EX
//   - multi-cycle holds while the shared iterative mul/div unit works in EX
// It also keeps stall and flush event counters for performance monitoring.
module hazard_stall_controller #(
    parameter int MD_LATENCY = 4,   // EX cycles per mul/div op, incl. completion (2..16)
    parameter int CNT_W      = 32   // performance counter width
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic             if_id_use_rs1,
    input  logic             if_id_use_rs2,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             ex_muldiv_valid,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_flush,
    output logic             ex_m_bubble,
    output logic             md_start,
    output logic             md_result_valid,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    localparam int MD_CNT_W = 4;
    // Cycles spent in MD_BUSY after the start cycle, minus one (counter hits
    // zero on the last busy cycle). Unused when the op needs no busy cycles.
    localparam logic [MD_CNT_W-1:0] MD_CNT_LOAD =
        (MD_LATENCY > 2) ? MD_CNT_W'(MD_LATENCY - 3) : {MD_CNT_W{1'b0}};
    localparam logic [MD_CNT_W-1:0] MD_CNT_ONE = {{(MD_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]    CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    md_state_t           md_state_r;
    md_state_t           md_state_next_s;
    logic [MD_CNT_W-1:0] md_cnt_r;
    logic [MD_CNT_W-1:0] md_cnt_next_s;
    logic [CNT_W-1:0]    stall_count_r;
    logic [CNT_W-1:0]    flush_count_r;
    logic                load_use_s;
    logic                flush_evt_s;

    // Load-use hazard: the EX load writes a register the ID instruction reads (x0 exempt).
    always_comb begin
        load_use_s = 1'b0;
        if (id_ex_mem_read && (id_ex_rd != 5'd0) &&
            ((if_id_use_rs1 && (if_id_rs1 == id_ex_rd)) ||
             (if_id_use_rs2 && (if_id_rs2 == id_ex_rd)))) begin
            load_use_s = 1'b1;
        end else begin
            load_use_s = 1'b0;
        end
    end

    // Next-state and stage-control decode; priority is mul/div > branch > load-use.
    always_comb begin
        md_state_next_s = md_state_r;
        md_cnt_next_s   = md_cnt_r;
        pc_write        = 1'b1;
        if_id_write     = 1'b1;
        if_id_flush     = 1'b0;
        id_ex_write     = 1'b1;
        id_ex_flush     = 1'b0;
        ex_m_bubble     = 1'b0;
        md_start        = 1'b0;
        md_result_valid = 1'b0;
        flush_evt_s     = 1'b0;

        if (rst_n) begin
            case (md_state_r)
                MD_IDLE: begin
                    if (ex_muldiv_valid) begin
                        md_start        = 1'b1;
                        ex_m_bubble     = 1'b1;
                        pc_write        = 1'b0;
                        if_id_write     = 1'b0;
                        id_ex_write     = 1'b0;
                        md_cnt_next_s   = MD_CNT_LOAD;
                        md_state_next_s = (MD_LATENCY > 2) ? MD_BUSY : MD_DONE;
                    end else if (ex_branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        flush_evt_s = 1'b1;
                    end else if (load_use_s) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                    end else begin
                        md_state_next_s = MD_IDLE;
                    end
                end
                MD_BUSY: begin
                    ex_m_bubble = 1'b1;
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_write = 1'b0;
                    if (md_cnt_r == {MD_CNT_W{1'b0}}) begin
                        md_state_next_s = MD_DONE;
                    end else begin
                        md_cnt_next_s = md_cnt_r - MD_CNT_ONE;
                    end
                end
                MD_DONE: begin
                    // ex_muldiv_valid here belongs to the retiring op.
                    md_result_valid = 1'b1;
                    md_state_next_s = MD_IDLE;
                end
                default: begin
                    md_state_next_s = MD_IDLE;
                    md_cnt_next_s   = {MD_CNT_W{1'b0}};
                end
            endcase
        end else begin
            // While reset is held the pipeline sees plain defaults.
            md_state_next_s = MD_IDLE;
            md_cnt_next_s   = {MD_CNT_W{1'b0}};
        end
    end

    // Mul/div sequencer state and down-counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            md_state_r <= MD_IDLE;
            md_cnt_r   <= {MD_CNT_W{1'b0}};
        end else begin
            md_state_r <= md_state_next_s;
            md_cnt_r   <= md_cnt_next_s;
        end
    end

    // Performance counters: stalled cycles and taken-branch flushes, wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_count_r <= {CNT_W{1'b0}};
            flush_count_r <= {CNT_W{1'b0}};
        end else begin
            if (!pc_write) begin
                stall_count_r <= stall_count_r + CNT_ONE;
            end else begin
                stall_count_r <= stall_count_r;
            end
            if (flush_evt_s) begin
                flush_count_r <= flush_count_r + CNT_ONE;
            end else begin
                flush_count_r <= flush_count_r;
            end
        end
    end

    assign stall_count = stall_count_r;
    assign flush_count = flush_count_r;

endmodule
